irq_scheduler: RTL and testbench
================================

# irq_scheduler

External-interrupt scheduler for the yrv_mcu `ei_req` input. It replaces the hard-wired 8 kHz latch with a programmable periodic tick source plus up to three debounced-free asynchronous event sources. Events are latched into pending bits, masked, and arbitrated one at a time onto `ei_req`, which is held until a level acknowledge. It sits in the top level between board I/O (keys, gpio), the MCU port registers (mask, ack) and the MCU.

## Interface
- `CLK_FREQUENCY`, 50_000_000: clock frequency in Hz.
- `TICK_HZ`, 8000: periodic tick rate; divider `DIV = CLK_FREQUENCY / TICK_HZ`, 6250 at defaults.
- `N_SRC`, 4: number of sources, 2..4; source 0 is the internal tick, sources 1..N_SRC-1 are external.
- `clk  in  1`: single clock, all logic on the rising edge.
- `reset  in  1`: asynchronous, active-high.
- `tick_en  in  1`: tick divider runs while high; held at 0 while low.
- `src_req  in  N_SRC-1`: asynchronous external requests; the rising edge is the event. `src_req[i-1]` feeds source i.
- `mask  in  N_SRC`: 1 = source eligible for arbitration, 0 = masked. Pending bits still latch while masked.
- `ack  in  1`: level acknowledge from the MCU port bit.
- `ei_req  out  1`: interrupt request to the MCU.
- `irq_id  out  2`: index of the source currently being served.
- `irq_pending  out  N_SRC`: raw pending bits.

## Operation
- Tick: counter `0..DIV-1`, width `$clog2(DIV)`, wraps to 0. A tick event is a single-cycle pulse while the counter equals `DIV-1` and `tick_en` is 1.
- External sources: 2-FF synchronizer, then a third register. Event = `s2 & ~s3`.
- Pending bit i: set on event i. Cleared when source i is acknowledged. If set and clear happen in the same cycle, set wins and the event is not lost.
- Eligible = `irq_pending & mask`.
- FSM:
  - IDLE: if eligible ≠ 0, latch the winner into `irq_id`, `ei_req <= 1`, go to ASSERT.
  - ASSERT: `ei_req` held at 1 regardless of later mask changes. On `ack == 1`: clear `pending[irq_id]`, `ei_req <= 0`, go to RELEASE.
  - RELEASE: wait for `ack == 0`, then go to IDLE. No new grant is made in this state.
- `irq_id` holds its value outside ASSERT until the next grant.
- Arbitration: fixed priority, lowest index wins (see Configuration).

## Timing
- Reset values: `ei_req = 0`, `irq_id = 0`, `irq_pending = 0`, FSM in IDLE, divider = 0, synchronizers = 0, round-robin pointer = `N_SRC-1`.
- External latency: edge 1 samples `src_req` high into s1; edge 2 produces the event; edge 3 sets pending; edge 4 sets `ei_req`/`irq_id` if the FSM is IDLE and the source is unmasked.
- Tick latency: the edge that loads `DIV-1` is followed by the pending set on the next edge and `ei_req` one edge after that.
- Ack: `ack` is sampled at edge n in ASSERT; `ei_req = 0` and the pending bit is cleared after edge n. The minimum gap between consecutive grants is 2 cycles (RELEASE plus ack low).
- Asynchronous reset mid-ASSERT: everything returns to reset values immediately; events in flight are discarded.
- A second event on a source that is already pending merges into the same bit; there is no counting.

## Configuration
- `IRQ_ROUND_ROBIN_EN`
  - Defined: rotating priority. The search starts at `last_grant+1` modulo `N_SRC`. The pointer updates at each grant.
  - Undefined: fixed priority, index 0 highest. The pointer logic is absent.

## Structure
- Package `irq_scheduler_pkg`:
  - state enum `irq_state_t` {IDLE, ASSERT, RELEASE};
  - `localparam` for max sources (4) and id width (2);
  - function `irq_div(clk_hz, tick_hz)`.
- Sub-module `irq_edge_sync`: 2-FF synchronizer + edge detect, one instance per external source, ports `clk`, `reset`, `async_in`, `event_o`.

## Test plan
- Defaults, `tick_en=1`, `mask=4'b1111`, `ack=0`: `irq_pending[0]` rises 6250 cycles after reset release, `ei_req` rises 1 cycle later with `irq_id=0`, and stays high with no ack.
- `src_req[1]` high for 3 cycles: `irq_pending[2]` at edge 3, `ei_req=1`/`irq_id=2` at edge 4. Ack pulse → `ei_req=0` and `irq_pending[2]=0` the next edge.
- Sources 1 and 3 fire in the same cycle, each ack held 1 cycle:
  - fixed priority grants id 1 then id 3;
  - with `IRQ_ROUND_ROBIN_EN` and last grant 2, grants id 3 then id 1.
- `mask[1]=0` with a source-1 event: `irq_pending[1]=1`, `ei_req` stays 0. Set `mask[1]=1` → `ei_req=1`, `irq_id=1` one edge later.
- New source-2 event coincident with the ack clear of source 2: `irq_pending[2]` remains 1, and source 2 is re-granted after ack falls.
- Assert `reset` while in ASSERT: `ei_req`, `irq_id` and `irq_pending` go to 0 immediately. After release, no grant occurs until a new event.

Source files
------------

// File: rtl/irq_scheduler_pkg.sv
// Shared types, limits and helpers for the external-interrupt scheduler.
package irq_scheduler_pkg;

  localparam int MAX_SRC = 4;
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    RELEASE
  } irq_state_t;

  function automatic int irq_div(input longint clk_hz, input longint tick_hz);
    return int'(clk_hz / tick_hz);
  endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchronizer for an asynchronous request, plus rising-edge detect.
module irq_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic event_o
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign event_o = s2 & ~s3;

endmodule

// File: rtl/irq_scheduler.sv
// Periodic tick plus external event sources, latched, masked and granted one at a time onto ei_req.
// Define IRQ_ROUND_ROBIN_EN for rotating priority; the default is fixed priority with index 0 highest.
module irq_scheduler
  import irq_scheduler_pkg::*;
#(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int TICK_HZ       = 8000,
  parameter int N_SRC         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic [N_SRC-2:0] src_req,
  input  logic [N_SRC-1:0] mask,
  input  logic             ack,
  output logic             ei_req,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] irq_pending
);

  localparam int DIV   = irq_div(CLK_FREQUENCY, TICK_HZ);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0]   tick_cnt;
  logic               tick_event;
  logic [N_SRC-1:0]   src_event;
  logic [N_SRC-1:0]   eligible;
  logic [MAX_SRC-1:0] elig_ext;
  logic [MAX_SRC-1:0] ack_onehot;
  logic [N_SRC-1:0]   ack_clear;
  logic [ID_W-1:0]    winner;
  irq_state_t         state;

  assign tick_event = tick_en && (tick_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (!tick_en || tick_event) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign src_event[0] = tick_event;

  for (genvar i = 1; i < N_SRC; i++) begin : g_sync
    irq_edge_sync u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (src_req[i-1]),
      .event_o  (src_event[i])
    );
  end

  // A new event on the source being acknowledged re-sets its bit in the same cycle.
  assign ack_onehot = MAX_SRC'(1) << irq_id;
  assign ack_clear  = (state == ASSERT && ack) ? N_SRC'(ack_onehot) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_pending <= '0;
    end else begin
      irq_pending <= (irq_pending & ~ack_clear) | src_event;
    end
  end

  assign eligible = irq_pending & mask;
  assign elig_ext = MAX_SRC'(eligible);

`ifdef IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] rr_idx;

  // Walk from the farthest offset down so the nearest eligible source after last_grant wins.
  always_comb begin
    winner = '0;
    rr_idx = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      rr_idx = ID_W'((int'(last_grant) + k) % N_SRC);
      if (elig_ext[rr_idx]) winner = rr_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= ID_W'(N_SRC - 1);
    end else if (state == IDLE && |eligible) begin
      last_grant <= winner;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (elig_ext[i]) winner = ID_W'(i);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ei_req <= 1'b0;
      irq_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            irq_id <= winner;
            ei_req <= 1'b1;
            state  <= ASSERT;
          end
        end
        ASSERT: begin
          if (ack) begin
            ei_req <= 1'b0;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ack) state <= IDLE;
        end
        default: begin
          ei_req <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_scheduler.sv
// Self-checking bench for irq_scheduler: directed scenarios plus randomized traffic against a reference model.
module tb_irq_scheduler;

  localparam int DIV = 6250;

`ifdef IRQ_ROUND_ROBIN_EN
  localparam logic [1:0] FIRST_ID  = 2'd3;
  localparam logic [1:0] SECOND_ID = 2'd1;
`else
  localparam logic [1:0] FIRST_ID  = 2'd1;
  localparam logic [1:0] SECOND_ID = 2'd3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_en = 1'b0;
  logic [2:0] src_req = 3'b000;
  logic [3:0] mask = 4'hF;
  logic       ack = 1'b0;
  logic       ei_req;
  logic [1:0] irq_id;
  logic [3:0] irq_pending;

  int vectors = 0;
  int miscompares = 0;

  irq_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .tick_en     (tick_en),
    .src_req     (src_req),
    .mask        (mask),
    .ack         (ack),
    .ei_req      (ei_req),
    .irq_id      (irq_id),
    .irq_pending (irq_pending)
  );

  always #5 clk = ~clk;

  // Reference model: events as delayed rising edges, pending as a set, grant as a three-phase handshake.
  bit [3:0] m_pend, m_ev, m_elig, m_newp;
  bit       m_ei;
  bit [1:0] m_id;
  bit [2:0] m_prev, m_rise0, m_rise1;
  int       m_phase, m_cnt, m_last, m_win, m_j;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = '0; m_ei = 1'b0; m_id = '0; m_phase = 0; m_cnt = 0; m_last = 3;
      m_prev = '0; m_rise0 = '0; m_rise1 = '0;
    end else begin
      m_ev   = {m_rise1, (tick_en && m_cnt == DIV - 1)};
      m_cnt  = tick_en ? (m_cnt + 1) % DIV : 0;
      m_elig = m_pend & mask;
      m_newp = m_pend;
      if (m_phase == 0 && m_elig != 0) begin
        m_win = 0;
`ifdef IRQ_ROUND_ROBIN_EN
        for (int k = 4; k >= 1; k--) begin
          m_j = (m_last + k) % 4;
          if (m_elig[m_j]) m_win = m_j;
        end
`else
        for (int i = 3; i >= 0; i--) if (m_elig[i]) m_win = i;
`endif
        m_id = 2'(m_win); m_ei = 1'b1; m_phase = 1; m_last = m_win;
      end else if (m_phase == 1 && ack) begin
        m_newp[m_id] = 1'b0; m_ei = 1'b0; m_phase = 2;
      end else if (m_phase == 2 && !ack) begin
        m_phase = 0;
      end
      m_pend  = m_newp | m_ev;
      m_rise1 = m_rise0;
      m_rise0 = src_req & ~m_prev;
      m_prev  = src_req;
    end
  end

  task automatic apply_reset();
    reset = 1'b1; tick_en = 1'b0; src_req = '0; mask = 4'hF; ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; tick_en = 1'b1; src_req = 3'b111; ack = 1'b1;
    wait_edges(3);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b0) begin
      miscompares++; $display("[TB] FAIL reset_hold: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b0);
    end
    apply_reset();
    wait_edges(3);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b0) begin
      miscompares++; $display("[TB] FAIL reset_idle: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b0);
    end
  endtask

  task automatic test_tick();
    apply_reset();
    tick_en = 1'b1;
    wait_edges(DIV - 1);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b0_00_0000) begin
      miscompares++; $display("[TB] FAIL tick_early: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b0_00_0000);
    end
    wait_edges(1);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b0_00_0001) begin
      miscompares++; $display("[TB] FAIL tick_pend: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b0_00_0001);
    end
    wait_edges(1);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b1_00_0001) begin
      miscompares++; $display("[TB] FAIL tick_grant: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b1_00_0001);
    end
    wait_edges(30);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b1_00_0001) begin
      miscompares++; $display("[TB] FAIL tick_hold: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b1_00_0001);
    end
    tick_en = 1'b0;
  endtask

  task automatic test_ext_latency();
    apply_reset();
    src_req = 3'b010;
    wait_edges(2);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b0_00_0000) begin
      miscompares++; $display("[TB] FAIL ext_edge2: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b0_00_0000);
    end
    wait_edges(1);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b0_00_0100) begin
      miscompares++; $display("[TB] FAIL ext_edge3: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b0_00_0100);
    end
    src_req = 3'b000;
    wait_edges(1);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b1_10_0100) begin
      miscompares++; $display("[TB] FAIL ext_edge4: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b1_10_0100);
    end
    ack = 1'b1;
    wait_edges(1);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b0_10_0000) begin
      miscompares++; $display("[TB] FAIL ext_ack: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b0_10_0000);
    end
    ack = 1'b0;
    wait_edges(2);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b0_10_0000) begin
      miscompares++; $display("[TB] FAIL ext_idhold: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b0_10_0000);
    end
  endtask

  task automatic test_priority();
    logic [3:0] rest;
    rest = 4'b1010 & ~(4'b0001 << FIRST_ID);
    apply_reset();
    src_req = 3'b010;
    wait_edges(3);
    src_req = 3'b000;
    wait_edges(1);
    ack = 1'b1; wait_edges(1);
    ack = 1'b0; wait_edges(1);
    src_req = 3'b101;
    wait_edges(3);
    vectors++;
    if ({ei_req, irq_pending} !== 5'b0_1010) begin
      miscompares++; $display("[TB] FAIL prio_pend: got %b want %b", {ei_req, irq_pending}, 5'b0_1010);
    end
    src_req = 3'b000;
    wait_edges(1);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== {1'b1, FIRST_ID, 4'b1010}) begin
      miscompares++; $display("[TB] FAIL prio_first: got %b want %b", {ei_req, irq_id, irq_pending}, {1'b1, FIRST_ID, 4'b1010});
    end
    ack = 1'b1; wait_edges(1);
    ack = 1'b0; wait_edges(2);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== {1'b1, SECOND_ID, rest}) begin
      miscompares++; $display("[TB] FAIL prio_second: got %b want %b", {ei_req, irq_id, irq_pending}, {1'b1, SECOND_ID, rest});
    end
    ack = 1'b1; wait_edges(1);
    ack = 1'b0;
    vectors++;
    if ({ei_req, irq_pending} !== 5'b0_0000) begin
      miscompares++; $display("[TB] FAIL prio_done: got %b want %b", {ei_req, irq_pending}, 5'b0_0000);
    end
  endtask

  task automatic test_mask();
    apply_reset();
    mask = 4'b1101;
    src_req = 3'b001;
    wait_edges(3);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b0_00_0010) begin
      miscompares++; $display("[TB] FAIL mask_pend: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b0_00_0010);
    end
    wait_edges(3);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b0_00_0010) begin
      miscompares++; $display("[TB] FAIL mask_block: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b0_00_0010);
    end
    mask = 4'hF;
    wait_edges(1);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b1_01_0010) begin
      miscompares++; $display("[TB] FAIL mask_open: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b1_01_0010);
    end
  endtask

  task automatic test_coincident();
    apply_reset();
    src_req = 3'b010;
    wait_edges(3);
    src_req = 3'b000;
    wait_edges(1);
    src_req = 3'b010;
    wait_edges(2);
    ack = 1'b1;
    wait_edges(1);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b0_10_0100) begin
      miscompares++; $display("[TB] FAIL coinc_keep: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b0_10_0100);
    end
    ack = 1'b0;
    wait_edges(2);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b1_10_0100) begin
      miscompares++; $display("[TB] FAIL coinc_regrant: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b1_10_0100);
    end
  endtask

  task automatic test_reset_mid_assert();
    apply_reset();
    src_req = 3'b001;
    wait_edges(4);
    src_req = 3'b011;
    wait_edges(1);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b0) begin
      miscompares++; $display("[TB] FAIL midrst_now: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b0);
    end
    src_req = 3'b000;
    wait_edges(2);
    reset = 1'b0;
    wait_edges(10);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b0) begin
      miscompares++; $display("[TB] FAIL midrst_quiet: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b0);
    end
    src_req = 3'b100;
    wait_edges(4);
    vectors++;
    if ({ei_req, irq_id, irq_pending} !== 7'b1_11_1000) begin
      miscompares++; $display("[TB] FAIL midrst_new: got %b want %b", {ei_req, irq_id, irq_pending}, 7'b1_11_1000);
    end
  endtask

  task automatic test_random();
    apply_reset();
    tick_en = 1'b1;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      vectors++;
      if ({ei_req, irq_id, irq_pending} !== {m_ei, m_id, m_pend}) begin
        miscompares++;
        $display("[TB] FAIL random cyc %0d: got %b want %b", cyc, {ei_req, irq_id, irq_pending}, {m_ei, m_id, m_pend});
      end
      if ($urandom_range(0, 5) == 0) src_req = src_req ^ 3'(3'b001 << $urandom_range(0, 2));
      if ($urandom_range(0, 31) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 3) == 0) ack = ~ack;
      if ($urandom_range(0, 1499) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_ext_latency();
    test_priority();
    test_mask();
    test_coincident();
    test_reset_mid_assert();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
